// File: rtl/otg_hpi_bus_ctrl.sv
// otg_hpi_bus_ctrl
// Avalon-MM slave that runs complete CY7C67200 HPI read/write cycles in
// hardware. Each access walks IDLE -> SETUP -> STROBE -> HOLD -> RECOVER
// with programmable phase lengths; the master is stalled through
// waitrequest until the final HOLD cycle.
module otg_hpi_bus_ctrl #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 3,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  otg_hpi_address,
    output logic        otg_hpi_cs_n,
    output logic        otg_hpi_r_n,
    output logic        otg_hpi_w_n,
    output logic [15:0] otg_hpi_data_out,
    output logic        otg_hpi_data_oe,
    input  logic [15:0] otg_hpi_data_in,
    output logic        busy
);

    // Counter only has to hold (phase length - 1) for the longest phase.
    localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_HR  = (HOLD_CYC > RECOVERY_CYC) ? HOLD_CYC : RECOVERY_CYC;
    localparam int MAX_CYC = (MAX_SS > MAX_HR) ? MAX_SS : MAX_HR;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD    = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD   = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD     = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVERY_LOAD = CNT_W'(RECOVERY_CYC - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             wr_flag;
    logic             next_wr_flag;
    logic             request;
    logic             accept;
    logic             last_cnt;
    logic             ack;
    logic             next_active;
    logic             capture_rd;

    // Avalon handshake: a write wins when read and write are both high.
    assign request     = chipselect & (read | write);
    assign last_cnt    = (cnt == '0);
    assign accept      = (state == ST_IDLE) & request;
    assign ack         = (state == ST_HOLD) & last_cnt;
    assign waitrequest = request & ~ack;
    assign busy        = (state != ST_IDLE);
    assign capture_rd  = (state == ST_STROBE) & last_cnt & ~wr_flag;

    // Next-state and phase counter: the counter is reloaded on every state entry.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case can leave one unassigned and infer a latch.
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_IDLE: begin
                if (request) begin
                    next_state = ST_SETUP;
                    next_cnt   = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (last_cnt) begin
                    next_state = ST_STROBE;
                    next_cnt   = STROBE_LOAD;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            ST_STROBE: begin
                if (last_cnt) begin
                    next_state = ST_HOLD;
                    next_cnt   = HOLD_LOAD;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (last_cnt) begin
                    next_state = ST_RECOVER;
                    next_cnt   = RECOVERY_LOAD;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            ST_RECOVER: begin
                if (last_cnt) begin
                    next_state = ST_IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt - 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Direction of the access being started, or the one already in flight.
    assign next_wr_flag = accept ? write : wr_flag;
    assign next_active  = (next_state == ST_SETUP) || (next_state == ST_STROBE) ||
                          (next_state == ST_HOLD);

    // FSM state, phase counter and latched access direction.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wr_flag <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            wr_flag <= next_wr_flag;
        end
    end

    // HPI control pins, registered from the next state so they change cleanly on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            otg_hpi_cs_n    <= 1'b1;
            otg_hpi_r_n     <= 1'b1;
            otg_hpi_w_n     <= 1'b1;
            otg_hpi_data_oe <= 1'b0;
        end else begin
            otg_hpi_cs_n    <= ~next_active;
            otg_hpi_r_n     <= ~((next_state == ST_STROBE) & ~next_wr_flag);
            otg_hpi_w_n     <= ~((next_state == ST_STROBE) & next_wr_flag);
            otg_hpi_data_oe <= next_active & next_wr_flag;
        end
    end

    // Address and write data are latched at acceptance and held for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            otg_hpi_address  <= 2'd0;
            otg_hpi_data_out <= 16'h0000;
        end else if (accept) begin
            otg_hpi_address <= address;
            if (write) begin
                otg_hpi_data_out <= writedata;
            end
        end
    end

    // Read data is captured on the edge that ends the last STROBE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 16'h0000;
        end else if (capture_rd) begin
            readdata <= otg_hpi_data_in;
        end
    end

endmodule

// File: tb/tb_otg_hpi_bus_ctrl.sv
// Directed bench for otg_hpi_bus_ctrl: a default-parameter instance for the
// cycle-exact scenarios and a second instance (SETUP=2, STROBE=5, HOLD=2,
// RECOVERY=3) for the phase-length sweep over random accesses.
module tb_otg_hpi_bus_ctrl;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic reset;

    // Default-parameter instance.
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        waitrequest;
    logic [1:0]  otg_hpi_address;
    logic        otg_hpi_cs_n;
    logic        otg_hpi_r_n;
    logic        otg_hpi_w_n;
    logic [15:0] otg_hpi_data_out;
    logic        otg_hpi_data_oe;
    logic [15:0] otg_hpi_data_in;
    logic        busy;

    // Swept-parameter instance.
    logic [1:0]  b_address;
    logic        b_chipselect;
    logic        b_read;
    logic        b_write;
    logic [15:0] b_writedata;
    logic [15:0] b_readdata;
    logic        b_waitrequest;
    logic [1:0]  b_otg_hpi_address;
    logic        b_otg_hpi_cs_n;
    logic        b_otg_hpi_r_n;
    logic        b_otg_hpi_w_n;
    logic [15:0] b_otg_hpi_data_out;
    logic        b_otg_hpi_data_oe;
    logic [15:0] b_otg_hpi_data_in;
    logic        b_busy;

    otg_hpi_bus_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .address          (address),
        .chipselect       (chipselect),
        .read             (read),
        .write            (write),
        .writedata        (writedata),
        .readdata         (readdata),
        .waitrequest      (waitrequest),
        .otg_hpi_address  (otg_hpi_address),
        .otg_hpi_cs_n     (otg_hpi_cs_n),
        .otg_hpi_r_n      (otg_hpi_r_n),
        .otg_hpi_w_n      (otg_hpi_w_n),
        .otg_hpi_data_out (otg_hpi_data_out),
        .otg_hpi_data_oe  (otg_hpi_data_oe),
        .otg_hpi_data_in  (otg_hpi_data_in),
        .busy             (busy)
    );

    otg_hpi_bus_ctrl #(
        .SETUP_CYC    (2),
        .STROBE_CYC   (5),
        .HOLD_CYC     (2),
        .RECOVERY_CYC (3)
    ) dut_b (
        .clk              (clk),
        .reset            (reset),
        .address          (b_address),
        .chipselect       (b_chipselect),
        .read             (b_read),
        .write            (b_write),
        .writedata        (b_writedata),
        .readdata         (b_readdata),
        .waitrequest      (b_waitrequest),
        .otg_hpi_address  (b_otg_hpi_address),
        .otg_hpi_cs_n     (b_otg_hpi_cs_n),
        .otg_hpi_r_n      (b_otg_hpi_r_n),
        .otg_hpi_w_n      (b_otg_hpi_w_n),
        .otg_hpi_data_out (b_otg_hpi_data_out),
        .otg_hpi_data_oe  (b_otg_hpi_data_oe),
        .otg_hpi_data_in  (b_otg_hpi_data_in),
        .busy             (b_busy)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Per-cycle traces of the default instance; bit/index k is cycle k.
    logic [15:0] tr_cs, tr_r, tr_w, tr_oe, tr_busy, tr_wait, tr_ack;
    logic [15:0] tr_dout  [16];
    logic [15:0] tr_rdata [16];
    logic [1:0]  tr_addr  [16];

    // Transaction list presented back to back with the request held.
    logic        t_rd   [2];
    logic        t_wr   [2];
    logic [1:0]  t_addr [2];
    logic [15:0] t_data [2];
    int          t_num;
    logic [15:0] rd_val;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_txn(input int i);
        chipselect = 1'b1;
        read       = t_rd[i];
        write      = t_wr[i];
        address    = t_addr[i];
        writedata  = t_data[i];
    endtask

    // Runs the transaction list on the default instance for ncyc cycles,
    // acting as the master (next transaction after each ack) and as the
    // HPI device (drives rd_val while r_n is low, zero otherwise).
    task automatic capture(input int ncyc);
        int idx;
        idx = 0;
        apply_txn(0);
        otg_hpi_data_in = 16'h0000;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            tr_cs[k]    = otg_hpi_cs_n;
            tr_r[k]     = otg_hpi_r_n;
            tr_w[k]     = otg_hpi_w_n;
            tr_oe[k]    = otg_hpi_data_oe;
            tr_busy[k]  = busy;
            tr_wait[k]  = waitrequest;
            tr_ack[k]   = chipselect & (read | write) & ~waitrequest;
            tr_dout[k]  = otg_hpi_data_out;
            tr_rdata[k] = readdata;
            tr_addr[k]  = otg_hpi_address;
            @(posedge clk);
            #1;
            if (tr_ack[k]) begin
                idx++;
                if (idx < t_num) begin
                    apply_txn(idx);
                end else begin
                    chipselect = 1'b0;
                    read       = 1'b0;
                    write      = 1'b0;
                end
            end
            otg_hpi_data_in = otg_hpi_r_n ? 16'h0000 : rd_val;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_data_oe, busy, waitrequest} !== 6'b111000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got cs_n,r_n,w_n,oe,busy,wait=%b expected 111000",
                     {otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_data_oe, busy, waitrequest});
        end
        vectors++;
        if ({readdata, otg_hpi_data_out, otg_hpi_address} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_data: got readdata=%h data_out=%h addr=%0d expected all zero",
                     readdata, otg_hpi_data_out, otg_hpi_address);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        // Write that is reset while its strobe is low (cycle 3).
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = 2'd2; writedata = 16'hABCD;
        idle(3);
        @(negedge clk);
        vectors++;
        if ({otg_hpi_cs_n, otg_hpi_w_n, otg_hpi_data_oe} !== 3'b001) begin
            miscompares++;
            $display("FAIL reset_pre_strobe: got cs_n,w_n,oe=%b expected 001",
                     {otg_hpi_cs_n, otg_hpi_w_n, otg_hpi_data_oe});
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if ({otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_data_oe, busy} !== 5'b11100) begin
            miscompares++;
            $display("FAIL reset_mid_strobe: got cs_n,r_n,w_n,oe,busy=%b expected 11100",
                     {otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_data_oe, busy});
        end
        vectors++;
        if (readdata !== 16'h0000 || waitrequest !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_no_ack: got readdata=%h wait=%b expected 0000 1", readdata, waitrequest);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        chipselect = 1'b0; write = 1'b0;
        idle(3);
        @(negedge clk);
        vectors++;
        if ({otg_hpi_cs_n, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_abandoned: got cs_n,busy=%b expected 10", {otg_hpi_cs_n, busy});
        end
        idle(1);
    endtask

    task automatic test_write;
        t_num = 1; t_rd[0] = 1'b0; t_wr[0] = 1'b1; t_addr[0] = 2'd2; t_data[0] = 16'h1234;
        rd_val = 16'hFFFF;
        capture(10);
        vectors++;
        if (tr_cs[9:0] !== 10'b1111000001) begin
            miscompares++; $display("FAIL write_cs_n: got %b expected %b", tr_cs[9:0], 10'b1111000001);
        end
        vectors++;
        if (tr_w[9:0] !== 10'b1111100011) begin
            miscompares++; $display("FAIL write_w_n: got %b expected %b", tr_w[9:0], 10'b1111100011);
        end
        vectors++;
        if (tr_r[9:0] !== 10'b1111111111) begin
            miscompares++; $display("FAIL write_r_n: got %b expected %b", tr_r[9:0], 10'b1111111111);
        end
        vectors++;
        if (tr_oe[9:0] !== 10'b0000111110) begin
            miscompares++; $display("FAIL write_oe: got %b expected %b", tr_oe[9:0], 10'b0000111110);
        end
        vectors++;
        if (tr_wait[5:0] !== 6'b011111) begin
            miscompares++; $display("FAIL write_wait: got %b expected %b", tr_wait[5:0], 6'b011111);
        end
        vectors++;
        if (tr_busy[9:0] !== 10'b0011111110) begin
            miscompares++; $display("FAIL write_busy: got %b expected %b", tr_busy[9:0], 10'b0011111110);
        end
        vectors++;
        if (tr_ack[9:0] !== 10'b0000100000) begin
            miscompares++; $display("FAIL write_ack: got %b expected %b", tr_ack[9:0], 10'b0000100000);
        end
        for (int k = 1; k <= 5; k++) begin
            vectors++;
            if (tr_dout[k] !== 16'h1234 || tr_addr[k] !== 2'd2) begin
                miscompares++;
                $display("FAIL write_bus cycle %0d: got data=%h addr=%0d expected 1234 2", k, tr_dout[k], tr_addr[k]);
            end
        end
        idle(2);
    endtask

    task automatic test_read;
        t_num = 1; t_rd[0] = 1'b1; t_wr[0] = 1'b0; t_addr[0] = 2'd0; t_data[0] = 16'h7777;
        rd_val = 16'hBEEF;
        capture(10);
        vectors++;
        if (tr_r[9:0] !== 10'b1111100011) begin
            miscompares++; $display("FAIL read_r_n: got %b expected %b", tr_r[9:0], 10'b1111100011);
        end
        vectors++;
        if (tr_w[9:0] !== 10'b1111111111 || tr_oe[9:0] !== 10'b0000000000) begin
            miscompares++; $display("FAIL read_w_n_oe: got w_n=%b oe=%b expected all 1 / all 0", tr_w[9:0], tr_oe[9:0]);
        end
        vectors++;
        if (tr_rdata[4] !== 16'h0000) begin
            miscompares++; $display("FAIL read_early: got %h expected 0000", tr_rdata[4]);
        end
        vectors++;
        if (tr_rdata[5] !== 16'hBEEF || tr_ack[5] !== 1'b1) begin
            miscompares++; $display("FAIL read_ack_data: got %h ack=%b expected BEEF 1", tr_rdata[5], tr_ack[5]);
        end
        vectors++;
        if (tr_rdata[9] !== 16'hBEEF) begin
            miscompares++; $display("FAIL read_hold: got %h expected BEEF", tr_rdata[9]);
        end
        vectors++;
        if (tr_addr[3] !== 2'd0) begin
            miscompares++; $display("FAIL read_addr: got %0d expected 0", tr_addr[3]);
        end
        idle(2);
    endtask

    task automatic test_back_to_back;
        int rise;
        int fall2;
        t_num = 2;
        t_rd[0] = 1'b0; t_wr[0] = 1'b1; t_addr[0] = 2'd1; t_data[0] = 16'h5A5A;
        t_rd[1] = 1'b1; t_wr[1] = 1'b0; t_addr[1] = 2'd3; t_data[1] = 16'h0000;
        rd_val = 16'h1357;
        capture(16);
        rise  = -1;
        fall2 = -1;
        for (int k = 1; k < 16; k++) begin
            if (rise < 0 && tr_cs[k-1] == 1'b0 && tr_cs[k] == 1'b1) rise = k;
            else if (rise >= 0 && fall2 < 0 && tr_cs[k-1] == 1'b1 && tr_cs[k] == 1'b0) fall2 = k;
        end
        vectors++;
        if (tr_cs !== 16'b1100000111000001) begin
            miscompares++; $display("FAIL b2b_cs_n: got %b expected %b", tr_cs, 16'b1100000111000001);
        end
        vectors++;
        if (rise < 0 || fall2 < 0 || fall2 - rise != 3) begin
            miscompares++; $display("FAIL b2b_gap: got rise=%0d fall=%0d expected gap 3", rise, fall2);
        end
        vectors++;
        if (tr_ack !== 16'b0010000000100000) begin
            miscompares++; $display("FAIL b2b_ack: got %b expected %b", tr_ack, 16'b0010000000100000);
        end
        vectors++;
        if (tr_wait[13:0] !== 14'b01111111011111) begin
            miscompares++; $display("FAIL b2b_wait: got %b expected %b", tr_wait[13:0], 14'b01111111011111);
        end
        vectors++;
        if (tr_w !== 16'hFFE3 || tr_r !== 16'hE3FF) begin
            miscompares++; $display("FAIL b2b_strobes: got w_n=%h r_n=%h expected FFE3 E3FF", tr_w, tr_r);
        end
        vectors++;
        if (tr_rdata[13] !== 16'h1357 || tr_addr[11] !== 2'd3 || tr_dout[3] !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL b2b_data: got rdata=%h addr=%0d wdata=%h expected 1357 3 5A5A",
                     tr_rdata[13], tr_addr[11], tr_dout[3]);
        end
        idle(2);
    endtask

    task automatic test_read_write_both;
        t_num = 1; t_rd[0] = 1'b1; t_wr[0] = 1'b1; t_addr[0] = 2'd1; t_data[0] = 16'h00A5;
        rd_val = 16'hFFFF;
        capture(10);
        vectors++;
        if (tr_w[9:0] !== 10'b1111100011 || tr_r[9:0] !== 10'b1111111111) begin
            miscompares++; $display("FAIL rw_strobes: got w_n=%b r_n=%b expected 1111100011 1111111111", tr_w[9:0], tr_r[9:0]);
        end
        vectors++;
        if (tr_oe[9:0] !== 10'b0000111110 || tr_dout[3] !== 16'h00A5) begin
            miscompares++; $display("FAIL rw_data: got oe=%b data=%h expected 0000111110 00A5", tr_oe[9:0], tr_dout[3]);
        end
        vectors++;
        if (tr_rdata[9] !== 16'h1357) begin
            miscompares++; $display("FAIL rw_readdata_kept: got %h expected 1357", tr_rdata[9]);
        end
        idle(2);
    endtask

    // SETUP=2, STROBE=5, HOLD=2, RECOVERY=3: cs_n low cycles 1-9, strobe low
    // 3-7, ack in cycle 9, busy through cycle 12, idle again in cycle 13.
    task automatic test_param_sweep;
        logic [13:0] s_cs, s_r, s_w, s_oe, s_busy, s_wait;
        logic [15:0] s_rdata;
        logic [15:0] d, v;
        logic [1:0]  a;
        logic        is_wr, acked, viol;
        int          op;
        for (int n = 0; n < 1000; n++) begin
            op    = int'($urandom_range(0, 2));
            is_wr = (op != 0);
            a     = 2'($urandom_range(0, 3));
            d     = 16'($urandom);
            v     = 16'($urandom);
            acked = 1'b0;
            s_rdata = 16'h0000;
            b_chipselect = 1'b1; b_read = (op != 1); b_write = (op != 0);
            b_address = a; b_writedata = d; b_otg_hpi_data_in = ~v;
            for (int k = 0; k < 14; k++) begin
                @(negedge clk);
                s_cs[k] = b_otg_hpi_cs_n; s_r[k] = b_otg_hpi_r_n; s_w[k] = b_otg_hpi_w_n;
                s_oe[k] = b_otg_hpi_data_oe; s_busy[k] = b_busy; s_wait[k] = b_waitrequest;
                if (k == 9) s_rdata = b_readdata;
                viol = (!b_otg_hpi_r_n && !b_otg_hpi_w_n) ||
                       ((!b_otg_hpi_r_n || !b_otg_hpi_w_n) && b_otg_hpi_cs_n) ||
                       (b_otg_hpi_data_oe && !is_wr) ||
                       (!b_otg_hpi_cs_n && b_otg_hpi_address !== a) ||
                       (b_otg_hpi_data_oe && b_otg_hpi_data_out !== d);
                vectors++;
                if (viol) begin
                    miscompares++;
                    $display("FAIL sweep_invariant access %0d cycle %0d: got cs_n=%b r_n=%b w_n=%b oe=%b addr=%0d data=%h expected legal strobes, addr=%0d data=%h",
                             n, k, b_otg_hpi_cs_n, b_otg_hpi_r_n, b_otg_hpi_w_n, b_otg_hpi_data_oe,
                             b_otg_hpi_address, b_otg_hpi_data_out, a, d);
                end
                if (b_chipselect && !b_waitrequest) acked = 1'b1;
                @(posedge clk);
                #1;
                if (acked) begin
                    b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0;
                end else begin
                    b_address = 2'($urandom_range(0, 3)); b_writedata = 16'($urandom);
                end
                b_otg_hpi_data_in = b_otg_hpi_r_n ? ~v : v;
            end
            vectors++;
            if (s_cs !== 14'b11110000000001 || s_busy !== 14'b01111111111110 || s_wait[9:0] !== 10'b0111111111) begin
                miscompares++;
                $display("FAIL sweep_phases access %0d: got cs_n=%b busy=%b wait=%b expected 11110000000001 01111111111110 0111111111",
                         n, s_cs, s_busy, s_wait[9:0]);
            end
            vectors++;
            if ((is_wr  && (s_w !== 14'b11111100000111 || s_r !== 14'h3FFF || s_oe !== 14'b00001111111110)) ||
                (!is_wr && (s_r !== 14'b11111100000111 || s_w !== 14'h3FFF || s_oe !== 14'h0000))) begin
                miscompares++;
                $display("FAIL sweep_strobe access %0d write=%b: got r_n=%b w_n=%b oe=%b expected strobe 11111100000111",
                         n, is_wr, s_r, s_w, s_oe);
            end
            if (!is_wr) begin
                vectors++;
                if (s_rdata !== v) begin
                    miscompares++;
                    $display("FAIL sweep_readdata access %0d: got %h expected %h", n, s_rdata, v);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        chipselect = 1'b0; read = 1'b0; write = 1'b0; address = 2'd0; writedata = 16'h0000;
        otg_hpi_data_in = 16'h0000;
        b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0; b_address = 2'd0; b_writedata = 16'h0000;
        b_otg_hpi_data_in = 16'h0000;
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_read_write_both;
        test_param_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/otg_hpi_bus_ctrl.md
Name: otg_hpi_bus_ctrl

Overview:
Avalon-MM slave that runs complete CY7C67200 HPI read and write cycles in hardware. Today, software bit-bangs those cycles through separate PIO ports (cs, rd, wr, addr, data). This block sits directly downstream of the Nios II data master and drives the OTG HPI pins itself. It generates the cs_n/r_n/w_n sequence with programmable setup, strobe, hold and recovery timing, and stalls the master with waitrequest until each access completes.

Parameters:
SETUP_CYC, 1, clocks with cs_n low and address stable before the strobe falls (must be ≥1)
STROBE_CYC, 3, clocks the r_n or w_n strobe is held low (must be ≥1)
HOLD_CYC, 1, clocks with cs_n low and address/data held after the strobe rises (must be ≥1)
RECOVERY_CYC, 2, clocks cs_n is high before the next access may begin (must be ≥1)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
address  in  2  HPI register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
chipselect  in  1  Avalon chipselect
read  in  1  Avalon read request
write  in  1  Avalon write request
writedata  in  16  Avalon write data
readdata  out  16  Avalon read data, registered
waitrequest  out  1  Avalon stall
otg_hpi_address  out  2  HPI address pins
otg_hpi_cs_n  out  1  HPI chip select, active low
otg_hpi_r_n  out  1  HPI read strobe, active low
otg_hpi_w_n  out  1  HPI write strobe, active low
otg_hpi_data_out  out  16  data driven to the HPI bus
otg_hpi_data_oe  out  1  tristate enable for otg_hpi_data_out (top level builds the inout)
otg_hpi_data_in  in  16  HPI bus sampled data
busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high. The reset port is named reset.
- Reset values: cs_n=1, r_n=1, w_n=1, data_oe=0, otg_hpi_address=0, data_out=0, readdata=0, busy=0, FSM=IDLE, counter=0.
- Reset mid-access: at the next edge, all strobes deassert, the bus is released and the transaction is abandoned. No ack is produced.
- Request = chipselect & (read | write). If read and write are both high, the access is a write.
- waitrequest = request & ~ack (combinational). ack is high for exactly one cycle, the final HOLD cycle. waitrequest is therefore high from the first request cycle until completion, including during RECOVER.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. One down-counter is reloaded on every state entry.
- IDLE: when request is sampled, latch address, the write flag and writedata; go to SETUP.
- SETUP (SETUP_CYC clocks): cs_n=0, address driven, r_n=w_n=1. data_oe=1 for a write.
- STROBE (STROBE_CYC clocks): r_n=0 (read) or w_n=0 (write). cs_n stays 0. data_oe stays 1 for a write.
- Read data: on the clock edge that ends the last STROBE cycle, capture otg_hpi_data_in into readdata. readdata holds until the next read capture.
- HOLD (HOLD_CYC clocks): strobes high, cs_n=0, address held, data_oe held for a write. ack is asserted in the last HOLD cycle.
- RECOVER (RECOVERY_CYC clocks): cs_n=1, data_oe=0. Then go to IDLE. A request pending during RECOVER stalls and starts from IDLE.
- Latency with defaults: the request is first seen in cycle 0 and waitrequest is low in cycle 5. The next access's cs_n falls no earlier than cycle 8.
- All HPI outputs are registered and glitch-free; each strobe has exactly one falling edge per access.
- The latched address and data hold for the whole access even if master inputs change. A request withdrawn mid-access does not abort the bus cycle.
- Strobe invariants: r_n and w_n are never both 0. Neither is 0 while cs_n=1. data_oe is never 1 during a read.

Test Plan:
- Reset: assert reset for 2 cycles mid-STROBE of a write -> next edge cs_n=1, w_n=1, data_oe=0, busy=0, readdata=0.
- Write 0x1234 to address 2 (defaults) -> cs_n low cycles 1–5, w_n low cycles 2–4, data_out=0x1234 with oe=1 cycles 1–5, waitrequest low only in cycle 5, cs_n high cycles 6–7.
- Read address 0 with otg_hpi_data_in=0xBEEF during STROBE, then 0x0000 after -> readdata=0xBEEF in the ack cycle; r_n low for 3 cycles; w_n and data_oe stay deasserted.
- Back-to-back write then read, request held -> second cs_n fall is exactly RECOVERY_CYC+1 cycles after the first cs_n rise; both acks occur once.
- read=write=1 with data 0x00A5 -> write cycle performed, w_n pulses, r_n stays 1.
- Parameter sweep SETUP=2, STROBE=5, HOLD=2, RECOVERY=3 -> the measured phase lengths match exactly and the invariant checker reports no violations over 1000 random accesses.
